// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: op fields, size codes, exception causes, FSM states.
package lsu_ctrl_pkg;

  typedef struct packed {
    logic       store;
    logic       uns;
    logic [1:0] size;
  } mem_op_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_LD_MISALIGN = 2'b01,
    CAUSE_ST_MISALIGN = 2'b10,
    CAUSE_BUS_FAULT   = 2'b11
  } exc_cause_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Doubleword accesses are only legal on a 64-bit datapath.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo,
                                      input logic d_legal);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lo[0];
      SZ_W:    misaligned = |lo[1:0];
      default: misaligned = !d_legal || (|lo);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store replication for the request side,
// lane extraction with sign/zero extension for returned load data.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BE_W  = XLEN / 8,
  parameter int OFF_W = $clog2(BE_W)
) (
  input  logic [1:0]       st_size_i,
  input  logic [OFF_W-1:0] st_off_i,
  input  logic [XLEN-1:0]  sdata_i,
  input  logic [1:0]       ld_size_i,
  input  logic             ld_unsigned_i,
  input  logic [OFF_W-1:0] ld_off_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  ldata_o
);

  logic [BE_W-1:0]        be_mask;
  logic [6:0]             sh;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        up;
  logic signed [XLEN-1:0] sext;

  always_comb begin
    case (st_size_i)
      SZ_B:    be_mask = BE_W'(1);
      SZ_H:    be_mask = BE_W'(3);
      SZ_W:    be_mask = BE_W'(15);
      default: be_mask = '1;
    endcase
  end

  assign be_o = be_mask << st_off_i;

  // Every lane carries the low bytes of the store data so any offset sees its data.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign wdata_o[8*gi +: 8] = (st_size_i == SZ_B) ? sdata_i[7:0] :
                                (st_size_i == SZ_H) ? sdata_i[8*(gi%2) +: 8] :
                                (st_size_i == SZ_W) ? sdata_i[8*(gi%4) +: 8] :
                                                      sdata_i[8*gi +: 8];
  end

  always_comb begin
    case (ld_size_i)
      SZ_B:    sh = 7'(XLEN - 8);
      SZ_H:    sh = 7'(XLEN - 16);
      SZ_W:    sh = 7'(XLEN - 32);
      default: sh = 7'd0;
    endcase
  end

  // Move the lane to the top, then shift back down logically or arithmetically.
  assign shifted = rdata_i >> {ld_off_i, 3'b000};
  assign up      = shifted << sh;
  assign sext    = $signed(up) >>> sh;
  assign ldata_o = ld_unsigned_i ? (up >> sh) : sext;

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: issues one req/ack bus transaction per memory op,
// stalls EX meanwhile, and registers writeback or a precise exception.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int BE_W    = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic            mem_en_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] sdata_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            int_assert_i,
  output logic            stall_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [BE_W-1:0] bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic            bus_err_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            exc_o,
  output logic [1:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_addr_o
);

  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(BE_W - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t          op_q, op_d;
  logic [4:0]       ld_wd_q, ld_wd_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d;
  logic             bus_we_q, bus_we_d;
  logic [BE_W-1:0]  bus_be_q, bus_be_d;
  logic [XLEN-1:0]  bus_wdata_q, bus_wdata_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wd_q, wd_d;
  logic             wreg_q, wreg_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             exc_q, exc_d;
  logic [1:0]       exc_cause_q, exc_cause_d;
  logic [XLEN-1:0]  exc_addr_q, exc_addr_d;

  logic            busy, mem_req, mis, timeout_hit, term;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] rep_c, ldata_c;

  lsu_align #(.XLEN(XLEN), .BE_W(BE_W), .OFF_W(OFF_W)) u_align (
    .st_size_i    (op_i[1:0]),
    .st_off_i     (addr_i[OFF_W-1:0]),
    .sdata_i      (sdata_i),
    .ld_size_i    (op_q.size),
    .ld_unsigned_i(op_q.uns),
    .ld_off_i     (req_addr_q[OFF_W-1:0]),
    .rdata_i      (bus_rdata_i),
    .be_o         (be_c),
    .wdata_o      (rep_c),
    .ldata_o      (ldata_c)
  );

  assign busy        = (state_q == ST_BUSY);
  assign mem_req     = (state_q == ST_IDLE) && ex_valid_i && mem_en_i && !int_assert_i;
  assign mis         = misaligned(op_i[1:0], addr_i[2:0], XLEN == 64);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign term        = busy && (bus_err_i || timeout_hit || bus_ack_i);
  // Gated by rst so an abandoned transaction releases the pipeline at once.
  assign stall_o     = !rst && ((mem_req && !mis) || (busy && !term));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ld_wd_d     = ld_wd_q;
    req_addr_d  = req_addr_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    exc_d       = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && !mem_en_i) begin
          wb_valid_d = 1'b1;
          wd_d       = wd_i;
          wreg_d     = wreg_i;
          wdata_d    = wdata_i;
        end else if (mem_req && mis) begin
          exc_d       = 1'b1;
          exc_cause_d = op_i[3] ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          exc_addr_d  = addr_i;
        end else if (mem_req) begin
          state_d     = ST_BUSY;
          cnt_d       = '0;
          op_d        = mem_op_t'(op_i);
          ld_wd_d     = wd_i;
          req_addr_d  = addr_i;
          bus_we_d    = op_i[3];
          bus_be_d    = be_c;
          bus_wdata_d = rep_c;
        end
      end
      ST_BUSY: begin
        if (bus_err_i || timeout_hit) begin
          state_d     = ST_IDLE;
          exc_d       = 1'b1;
          exc_cause_d = CAUSE_BUS_FAULT;
          exc_addr_d  = req_addr_q;
        end else if (bus_ack_i) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wd_d       = ld_wd_q;
          wreg_d     = !op_q.store;
          wdata_d    = op_q.store ? '0 : ldata_c;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      ld_wd_q     <= '0;
      req_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      exc_q       <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ld_wd_q     <= ld_wd_d;
      req_addr_q  <= req_addr_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      exc_q       <= exc_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign bus_req_o   = busy;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = req_addr_q & ADDR_MASK;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign exc_o       = exc_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_addr_o  = exc_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench: a 32-bit LSU with a short bus timeout and a 64-bit LSU, driven from a vector table.
module tb_lsu_ctrl;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [63:0] Z = '0;
  localparam int TO32 = 4;
  localparam int TO64 = 255;

  typedef struct {
    logic        x64;
    logic        mem;
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic [63:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        intr;
    int          ack_at;
    logic        err;
    logic        e_req;
    logic        e_we;
    logic [7:0]  e_be;
    logic [63:0] e_bw;
    logic        e_wb;
    logic        e_wreg;
    logic [63:0] e_wdata;
    logic        e_exc;
    logic [1:0]  e_cause;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel64, ev, ack, err, mem_en, intr, wreg;
  logic [3:0]  op;
  logic [63:0] addr, sdata, rdata, wdata;
  logic [4:0]  wd;
  logic        ev32, ev64, ack32, ack64, err32, err64;

  assign ev32  = ev & ~sel64;
  assign ev64  = ev & sel64;
  assign ack32 = ack & ~sel64;
  assign ack64 = ack & sel64;
  assign err32 = err & ~sel64;
  assign err64 = err & sel64;

  logic        stall32, req32, we32, wbv32, wreg32, exc32;
  logic [31:0] baddr32, bw32, wdo32, eaddr32;
  logic [3:0]  be32;
  logic [4:0]  wd32;
  logic [1:0]  cause32;
  logic        stall64, req64, we64, wbv64, wreg64, exc64;
  logic [63:0] baddr64, bw64, wdo64, eaddr64;
  logic [7:0]  be64;
  logic [4:0]  wd64;
  logic [1:0]  cause64;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(TO32)) dut32 (
    .clk(clk), .rst(rst), .ex_valid_i(ev32), .mem_en_i(mem_en), .op_i(op),
    .addr_i(addr[31:0]), .sdata_i(sdata[31:0]), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata[31:0]),
    .int_assert_i(intr), .stall_o(stall32), .bus_req_o(req32), .bus_we_o(we32),
    .bus_addr_o(baddr32), .bus_be_o(be32), .bus_wdata_o(bw32), .bus_ack_i(ack32),
    .bus_err_i(err32), .bus_rdata_i(rdata[31:0]), .wb_valid_o(wbv32), .wd_o(wd32),
    .wreg_o(wreg32), .wdata_o(wdo32), .exc_o(exc32), .exc_cause_o(cause32), .exc_addr_o(eaddr32)
  );

  lsu_ctrl #(.XLEN(64), .TIMEOUT(TO64)) dut64 (
    .clk(clk), .rst(rst), .ex_valid_i(ev64), .mem_en_i(mem_en), .op_i(op),
    .addr_i(addr), .sdata_i(sdata), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
    .int_assert_i(intr), .stall_o(stall64), .bus_req_o(req64), .bus_we_o(we64),
    .bus_addr_o(baddr64), .bus_be_o(be64), .bus_wdata_o(bw64), .bus_ack_i(ack64),
    .bus_err_i(err64), .bus_rdata_i(rdata), .wb_valid_o(wbv64), .wd_o(wd64),
    .wreg_o(wreg64), .wdata_o(wdo64), .exc_o(exc64), .exc_cause_o(cause64), .exc_addr_o(eaddr64)
  );

  // Observation view of whichever DUT the current vector targets.
  logic        s_stall, s_req, s_we, s_wbv, s_wreg, s_exc;
  logic [63:0] s_baddr, s_bw, s_wdata, s_eaddr;
  logic [7:0]  s_be;
  logic [4:0]  s_wd;
  logic [1:0]  s_cause;
  assign s_stall = sel64 ? stall64 : stall32;
  assign s_req   = sel64 ? req64   : req32;
  assign s_we    = sel64 ? we64    : we32;
  assign s_wbv   = sel64 ? wbv64   : wbv32;
  assign s_wreg  = sel64 ? wreg64  : wreg32;
  assign s_exc   = sel64 ? exc64   : exc32;
  assign s_baddr = sel64 ? baddr64 : {32'h0, baddr32};
  assign s_bw    = sel64 ? bw64    : {32'h0, bw32};
  assign s_wdata = sel64 ? wdo64   : {32'h0, wdo32};
  assign s_eaddr = sel64 ? eaddr64 : {32'h0, eaddr32};
  assign s_be    = sel64 ? be64    : {4'h0, be32};
  assign s_wd    = sel64 ? wd64    : wd32;
  assign s_cause = sel64 ? cause64 : cause32;

  int checks = 0;
  int failures = 0;
  vec_t vecs[0:21];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    int term;
    int c;
    logic [63:0] amask;
    amask = v.x64 ? ~64'h7 : ~64'h3;
    term  = (v.ack_at > 0) ? v.ack_at : (v.x64 ? TO64 : TO32);
    sel64 = v.x64; ev = 1'b1; mem_en = v.mem; op = v.op; addr = v.addr; sdata = v.sdata;
    wd = v.wd; wreg = v.wreg; wdata = v.wdata; intr = v.intr; rdata = Z;
    #1;
    check("stall_c0", s_stall, v.e_req);
    @(posedge clk); #1;
    ev = 1'b0; mem_en = 1'b0; intr = 1'b0; op = 4'h0; addr = Z; sdata = Z; wdata = Z;
    if (v.e_req) begin
      check("bus_req", s_req, 1);
      check("bus_we", s_we, v.e_we);
      check("bus_be", s_be, v.e_be);
      check("bus_wdata", s_bw, v.e_bw);
      check("bus_addr", s_baddr, v.addr & amask);
      c = 1;
      while (c < term) begin
        check("stall_busy", s_stall, 1);
        @(posedge clk); #1;
        c++;
        check("bus_be_hold", s_be, v.e_be);
      end
      ack = (v.ack_at > 0); err = v.err; rdata = v.rdata;
      #1;
      check("stall_term", s_stall, 0);
      @(posedge clk); #1;
      ack = 1'b0; err = 1'b0; rdata = Z;
    end
    check("wb_valid", s_wbv, v.e_wb);
    check("exc", s_exc, v.e_exc);
    check("req_after", s_req, 0);
    if (v.e_wb) begin
      check("wd", s_wd, v.wd);
      check("wreg", s_wreg, v.e_wreg);
      if (v.e_wreg) check("wdata", s_wdata, v.e_wdata);
    end
    if (v.e_exc) begin
      check("exc_cause", s_cause, v.e_cause);
      check("exc_addr", s_eaddr, v.addr);
    end
    @(posedge clk); #1;
    check("pulse_end", {s_wbv, s_exc}, 0);
    $display("txn %0d xlen=%0d op=%b addr=%h checks=%0d failures=%0d",
             idx, v.x64 ? 64 : 32, v.op, v.addr, checks, failures);
  endtask

  initial begin
    //          x64 mem op       addr        sdata                  rdata                  wdata           wd   wreg intr ack err  req we be     bw                     wb wreg wdata                  exc cause
    vecs[0]  = '{N, Y, 4'b0000, 64'h1003, Z,                     64'h80FF_FF12,         Z,              5'd1,  N, N, 1, N,  Y, N, 8'h08, Z,                     Y, Y, 64'hFFFF_FF80,         N, 2'd0};
    vecs[1]  = '{N, Y, 4'b0100, 64'h1003, Z,                     64'h80FF_FF12,         Z,              5'd2,  N, N, 2, N,  Y, N, 8'h08, Z,                     Y, Y, 64'h0000_0080,         N, 2'd0};
    vecs[2]  = '{N, Y, 4'b1001, 64'h2002, 64'h1234_ABCD,         Z,                     Z,              5'd3,  N, N, 1, N,  Y, Y, 8'h0C, 64'hABCD_ABCD,         Y, N, Z,                     N, 2'd0};
    vecs[3]  = '{N, Y, 4'b0010, 64'h3001, Z,                     Z,                     Z,              5'd4,  N, N, 0, N,  N, N, 8'h00, Z,                     N, N, Z,                     Y, 2'd1};
    vecs[4]  = '{N, Y, 4'b1010, 64'h4002, 64'h5555,              Z,                     Z,              5'd5,  N, N, 0, N,  N, N, 8'h00, Z,                     N, N, Z,                     Y, 2'd2};
    vecs[5]  = '{N, N, 4'b0010, 64'h5555, Z,                     Z,                     64'hDEAD_BEEF,  5'd7,  Y, N, 0, N,  N, N, 8'h00, Z,                     Y, Y, 64'hDEAD_BEEF,         N, 2'd0};
    vecs[6]  = '{N, Y, 4'b0001, 64'h5002, Z,                     64'h8001_7FFF,         Z,              5'd8,  N, N, 3, N,  Y, N, 8'h0C, Z,                     Y, Y, 64'hFFFF_8001,         N, 2'd0};
    vecs[7]  = '{N, Y, 4'b0101, 64'h5000, Z,                     64'h1234_F00D,         Z,              5'd9,  N, N, 1, N,  Y, N, 8'h03, Z,                     Y, Y, 64'h0000_F00D,         N, 2'd0};
    vecs[8]  = '{N, Y, 4'b0010, 64'h6000, Z,                     64'hCAFE_BABE,         Z,              5'd10, N, N, 1, N,  Y, N, 8'h0F, Z,                     Y, Y, 64'hCAFE_BABE,         N, 2'd0};
    vecs[9]  = '{N, Y, 4'b1000, 64'h7001, 64'h0000_00A5,         Z,                     Z,              5'd11, N, N, 2, N,  Y, Y, 8'h02, 64'hA5A5_A5A5,         Y, N, Z,                     N, 2'd0};
    vecs[10] = '{N, Y, 4'b0011, 64'h8000, Z,                     Z,                     Z,              5'd12, N, N, 0, N,  N, N, 8'h00, Z,                     N, N, Z,                     Y, 2'd1};
    vecs[11] = '{N, Y, 4'b0010, 64'h6000, Z,                     Z,                     Z,              5'd13, N, Y, 1, N,  N, N, 8'h00, Z,                     N, N, Z,                     N, 2'd0};
    vecs[12] = '{N, Y, 4'b0010, 64'h9000, Z,                     64'h1111_1111,         Z,              5'd14, N, N, 2, Y,  Y, N, 8'h0F, Z,                     N, N, Z,                     Y, 2'd3};
    vecs[13] = '{N, Y, 4'b0101, 64'hA000, Z,                     Z,                     Z,              5'd15, N, N, 0, N,  Y, N, 8'h03, Z,                     N, N, Z,                     Y, 2'd3};
    vecs[14] = '{N, Y, 4'b0000, 64'h1000, Z,                     64'h0000_007F,         Z,              5'd16, N, N, 1, N,  Y, N, 8'h01, Z,                     Y, Y, 64'h0000_007F,         N, 2'd0};
    vecs[15] = '{Y, Y, 4'b0011, 64'h0008, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, Z,       5'd17, N, N, 1, N,  Y, N, 8'hFF, 64'h8000_0000_0000_0001, Y, Y, 64'h8000_0000_0000_0001, N, 2'd0};
    vecs[16] = '{Y, Y, 4'b0011, 64'h0010, Z,                     64'h0000_0000_0000_0001, Z,            5'd18, N, N, 2, Y,  Y, N, 8'hFF, Z,                     N, N, Z,                     Y, 2'd3};
    vecs[17] = '{Y, Y, 4'b0010, 64'h0004, Z,                     64'h8765_4321_0000_0000, Z,            5'd19, N, N, 1, N,  Y, N, 8'hF0, Z,                     Y, Y, 64'hFFFF_FFFF_8765_4321, N, 2'd0};
    vecs[18] = '{Y, Y, 4'b1010, 64'h0010, 64'h1122_3344,         Z,                     Z,              5'd20, N, N, 1, N,  Y, Y, 8'h0F, 64'h1122_3344_1122_3344, Y, N, Z,                   N, 2'd0};
    vecs[19] = '{Y, Y, 4'b0110, 64'h0004, Z,                     64'h8765_4321_0000_0000, Z,            5'd21, N, N, 1, N,  Y, N, 8'hF0, Z,                     Y, Y, 64'h0000_0000_8765_4321, N, 2'd0};
    vecs[20] = '{Y, Y, 4'b0011, 64'h0014, Z,                     Z,                     Z,              5'd22, N, N, 0, N,  N, N, 8'h00, Z,                     N, N, Z,                     Y, 2'd1};
    vecs[21] = '{Y, Y, 4'b1001, 64'h0006, 64'h0000_BEEF,         Z,                     Z,              5'd23, N, N, 1, N,  Y, Y, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, Y, N, Z,                   N, 2'd0};

    rst = 1'b1; sel64 = 1'b0; ev = 1'b0; ack = 1'b0; err = 1'b0; mem_en = 1'b0; intr = 1'b0;
    wreg = 1'b0; op = 4'h0; addr = Z; sdata = Z; rdata = Z; wdata = Z; wd = 5'd0;
    #12;
    check("rst_ctl32", {stall32, req32, we32, wbv32, wreg32, exc32, be32, wd32, cause32}, 0);
    check("rst_data32", {32'h0, baddr32 | bw32 | wdo32 | eaddr32}, 0);
    check("rst_ctl64", {stall64, req64, we64, wbv64, wreg64, exc64, be64, wd64, cause64}, 0);
    check("rst_data64", baddr64 | bw64 | wdo64 | eaddr64, 0);
    $display("txn reset checks=%0d failures=%0d", checks, failures);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i <= 14; i++) run(i, vecs[i]);

    // Reset while a load is outstanding: request and stall must vanish without a writeback.
    sel64 = 1'b0; ev = 1'b1; mem_en = 1'b1; op = 4'b0010; addr = 64'h6000; wd = 5'd30;
    @(posedge clk); #1;
    ev = 1'b0; mem_en = 1'b0; op = 4'h0; addr = Z;
    check("rst_pre_req", s_req, 1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rst_mid_req", s_req, 0);
    check("rst_mid_stall", s_stall, 0);
    check("rst_mid_wb", s_wbv, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_after_quiet", {s_wbv, s_req, s_exc}, 0);
    end
    $display("txn rst_mid checks=%0d failures=%0d", checks, failures);
    run(99, vecs[11]);

    for (int i = 15; i <= 21; i++) run(i, vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
